// File: rtl/io_channel_unit_if.sv
// Core-facing channel bus, keyboard input and downlink FIFO port of io_channel_unit.
// Downlink handshake: a word transfers on a rising clock edge where dout_valid and dout_ready are both high; dout_data holds steady while dout_valid is high and dout_ready is low.
interface io_channel_unit_if;
   logic [4:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic        IO_write_en_F;
   logic [4:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic        key_valid;
   logic [4:0]  key_code;
   logic        dout_valid;
   logic [14:0] dout_data;
   logic        dout_ready;

   modport slave (
      input  IO_write_sel, IO_write_data, IO_write_en_F, IO_read_sel,
      input  key_valid, key_code, dout_ready,
      output IO_read_data, dout_valid, dout_data
   );

   modport master (
      output IO_write_sel, IO_write_data, IO_write_en_F, IO_read_sel,
      output key_valid, key_code, dout_ready,
      input  IO_read_data, dout_valid, dout_data
   );
endinterface

// File: rtl/io_channel_unit.sv
// 32-channel IO register file with a TIME counter, a DSKY downlink FIFO,
// a read-only status channel and a single-entry keyboard latch.
module io_channel_unit #(
   parameter int FIFO_DEPTH = 4,
   parameter int TICK_DIV   = 1000
) (
   input logic         clock,
   input logic         reset_n,
   io_channel_unit_if.slave io
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TICK_DIV);

   localparam logic [4:0] CH_TIME = 5'd3;
   localparam logic [4:0] CH_DSKY = 5'd10;
   localparam logic [4:0] CH_STAT = 5'd13;
   localparam logic [4:0] CH_KEY  = 5'd15;

   logic [14:0]   ch [32];
   logic [TW-1:0] presc;
   logic          key_pending;

   logic [14:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic fifo_empty, fifo_full, pop, push_req, push, tick;
   logic wr_time, wr_stat, wr_key;
   logic [14:0] status;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign pop        = !fifo_empty && io.dout_ready;
   assign push_req   = io.IO_write_en_F && (io.IO_write_sel == CH_DSKY);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push       = push_req && (!fifo_full || pop);
   assign tick       = (presc == TW'(TICK_DIV - 1));

   assign wr_time = io.IO_write_en_F && (io.IO_write_sel == CH_TIME);
   assign wr_stat = io.IO_write_en_F && (io.IO_write_sel == CH_STAT);
   assign wr_key  = io.IO_write_en_F && (io.IO_write_sel == CH_KEY);

   assign status = {11'b0, key_pending, overflow, fifo_full, fifo_empty};

   assign io.IO_read_data = (io.IO_read_sel == CH_STAT) ? status : ch[io.IO_read_sel];
   assign io.dout_valid   = !fifo_empty;
   assign io.dout_data    = fifo_mem[rd_ptr];

   // Channel registers; ch[13] is never written because status is synthesised on read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) ch[i] <= '0;
         presc       <= '0;
         key_pending <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (io.IO_write_en_F && (io.IO_write_sel == 5'(i)) &&
                (5'(i) != CH_TIME) && (5'(i) != CH_STAT) && (5'(i) != CH_KEY))
               ch[i] <= io.IO_write_data;
         end

         if (wr_time) begin
            ch[CH_TIME] <= io.IO_write_data;
            presc       <= '0;
         end else if (tick) begin
            ch[CH_TIME] <= ch[CH_TIME] + 15'd1;
            presc       <= '0;
         end else begin
            presc <= presc + TW'(1);
         end

         if (wr_key) begin
            ch[CH_KEY]  <= '0;
            key_pending <= 1'b0;
         end else if (io.key_valid && !key_pending) begin
            ch[CH_KEY]  <= {10'b0, io.key_code};
            key_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= io.IO_write_data;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // Setting overflow takes priority over a same-cycle clear.
         if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
         else if (wr_stat && io.IO_write_data[2])
            overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit with FIFO_DEPTH = 4 and TICK_DIV = 4.
module tb_io_channel_unit;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   io_channel_unit_if bus();

   io_channel_unit #(.FIFO_DEPTH(DEPTH), .TICK_DIV(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .io      (bus)
   );

   always #10 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   logic [14:0] exp_q[$];

   typedef struct {
      logic [4:0]  sel;
      logic [14:0] data;
      logic [14:0] exp_before;
      logic [14:0] exp_after;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic read_check(input string name, input logic [4:0] sel, input logic [14:0] exp);
      bus.IO_read_sel = sel;
      #1;
      check(name, bus.IO_read_data, exp);
   endtask

   // One clock cycle with inputs already driven: scoreboard checks, then the edge.
   task automatic tick_cycle();
      bit pop_now;
      #2;
      pop_now = bus.dout_ready && (exp_q.size() != 0);
      check("dout_valid", {14'b0, bus.dout_valid}, {14'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("dout_data", bus.dout_data, exp_q[0]);
      if (pop_now) void'(exp_q.pop_front());
      if (bus.IO_write_en_F && bus.IO_write_sel == 5'd10 &&
          (exp_q.size() < DEPTH || pop_now))
         exp_q.push_back(bus.IO_write_data);
      step();
   endtask

   task automatic wr(input logic [4:0] sel, input logic [14:0] d);
      bus.IO_write_en_F = 1'b1;
      bus.IO_write_sel  = sel;
      bus.IO_write_data = d;
      tick_cycle();
      bus.IO_write_en_F = 1'b0;
   endtask

   task automatic drain();
      bus.dout_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick_cycle();
      check("drain_budget", 15'(exp_q.size()), 15'd0);
      tick_cycle();
      bus.dout_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{5'd5,  15'h1234, 15'h0000, 15'h1234};
      vecs[1] = '{5'd0,  15'h7FFF, 15'h0000, 15'h7FFF};
      vecs[2] = '{5'd31, 15'h0001, 15'h0000, 15'h0001};
      vecs[3] = '{5'd14, 15'h5555, 15'h0000, 15'h5555};
      vecs[4] = '{5'd5,  15'h0ABC, 15'h1234, 15'h0ABC};
      vecs[5] = '{5'd16, 15'h2AAA, 15'h0000, 15'h2AAA};
      vecs[6] = '{5'd2,  15'h0F0F, 15'h0000, 15'h0F0F};
      vecs[7] = '{5'd0,  15'h0000, 15'h7FFF, 15'h0000};

      bus.IO_write_sel  = '0;
      bus.IO_write_data = '0;
      bus.IO_write_en_F = 1'b0;
      bus.IO_read_sel   = '0;
      bus.key_valid     = 1'b0;
      bus.key_code      = '0;
      bus.dout_ready    = 1'b0;

      // Reset values
      #3;
      check("rst_dout_valid", {14'b0, bus.dout_valid}, 15'd0);
      check("rst_dout_data", bus.dout_data, 15'd0);
      read_check("rst_ch0", 5'd0, 15'h0000);
      read_check("rst_ch13", 5'd13, 15'h0001);
      read_check("rst_ch3", 5'd3, 15'h0000);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();

      // Plain storage, no read bypass
      foreach (vecs[i]) begin
         read_check($sformatf("plain_before[%0d]", i), vecs[i].sel, vecs[i].exp_before);
         wr(vecs[i].sel, vecs[i].data);
         read_check($sformatf("plain_after[%0d]", i), vecs[i].sel, vecs[i].exp_after);
      end

      // TIME channel wrap and write-on-wrap
      wr(5'd3, 15'h7FFE);
      repeat (3) tick_cycle();
      read_check("time_e3", 5'd3, 15'h7FFE);
      tick_cycle();
      read_check("time_e4", 5'd3, 15'h7FFF);
      repeat (3) tick_cycle();
      read_check("time_e7", 5'd3, 15'h7FFF);
      tick_cycle();
      read_check("time_wrap", 5'd3, 15'h0000);
      repeat (3) tick_cycle();
      wr(5'd3, 15'h0100);
      read_check("time_wr_on_wrap", 5'd3, 15'h0100);
      repeat (3) tick_cycle();
      read_check("time_after_load3", 5'd3, 15'h0100);
      tick_cycle();
      read_check("time_after_load4", 5'd3, 15'h0101);

      // FIFO fill, overflow, drain and status clear
      bus.dout_ready = 1'b0;
      wr(5'd10, 15'd1);
      wr(5'd10, 15'd2);
      wr(5'd10, 15'd3);
      wr(5'd10, 15'd4);
      wr(5'd10, 15'd5);
      read_check("stat_full_ovf", 5'd13, 15'h0006);
      read_check("ch10_stored", 5'd10, 15'h0005);
      repeat (2) tick_cycle();
      wr(5'd13, 15'h7FFB);
      read_check("stat_clear_bit2_zero", 5'd13, 15'h0006);
      drain();
      read_check("stat_after_drain", 5'd13, 15'h0005);
      wr(5'd13, 15'h0004);
      read_check("stat_ovf_cleared", 5'd13, 15'h0001);

      // Push and pop while full
      wr(5'd10, 15'd5);
      wr(5'd10, 15'd6);
      wr(5'd10, 15'd7);
      wr(5'd10, 15'd8);
      read_check("stat_full", 5'd13, 15'h0002);
      bus.dout_ready = 1'b1;
      wr(5'd10, 15'd9);
      bus.dout_ready = 1'b0;
      read_check("stat_full_no_ovf", 5'd13, 15'h0002);
      check("queue_has_9_last", exp_q[DEPTH-1], 15'd9);
      drain();

      // Keyboard latch
      bus.key_valid = 1'b1;
      bus.key_code  = 5'h12;
      tick_cycle();
      bus.key_code  = 5'h07;
      tick_cycle();
      bus.key_valid = 1'b0;
      read_check("key_first", 5'd15, 15'h0012);
      read_check("key_stat", 5'd13, 15'h0009);
      wr(5'd15, 15'h7FFF);
      read_check("key_cleared", 5'd15, 15'h0000);
      read_check("key_stat_cleared", 5'd13, 15'h0001);
      bus.key_valid = 1'b1;
      tick_cycle();
      bus.key_valid = 1'b0;
      read_check("key_second", 5'd15, 15'h0007);
      bus.key_valid = 1'b1;
      bus.key_code  = 5'h1F;
      wr(5'd15, 15'h0000);
      bus.key_valid = 1'b0;
      read_check("key_write_wins", 5'd15, 15'h0000);
      read_check("key_write_wins_stat", 5'd13, 15'h0001);
      bus.key_valid = 1'b1;
      tick_cycle();
      bus.key_valid = 1'b0;
      read_check("key_third", 5'd15, 15'h001F);

      // Mid-stream asynchronous reset
      wr(5'd10, 15'h000A);
      wr(5'd10, 15'h000B);
      wr(5'd10, 15'h000C);
      read_check("stat_before_reset", 5'd13, 15'h0008);
      reset_n = 1'b0;
      #1;
      check("arst_dout_valid", {14'b0, bus.dout_valid}, 15'd0);
      check("arst_dout_data", bus.dout_data, 15'd0);
      read_check("arst_ch13", 5'd13, 15'h0001);
      read_check("arst_ch3", 5'd3, 15'h0000);
      read_check("arst_ch15", 5'd15, 15'h0000);
      exp_q.delete();
      step();
      reset_n = 1'b1;
      read_check("arst_ch5", 5'd5, 15'h0000);
      tick_cycle();
      wr(5'd10, 15'h0033);
      drain();
      read_check("post_reset_stat", 5'd13, 15'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
